// File: rtl/secure_mem_requester_if.sv
// Client-side request/response bus of the secure memory requester.
// master: the client issuing requests; slave: the requester block.
interface secure_mem_requester_if #(
   parameter int unsigned WIDTH = 256,
   parameter int unsigned AW    = 4
);
   logic             req_valid;
   logic             req_ready;
   logic             req_write;
   logic [AW-1:0]    req_addr;
   logic [WIDTH-1:0] req_wdata;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_rdata;
   logic             rsp_err;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/secure_mem_requester.sv
// Single-outstanding request sequencer in front of a secure memory.
// Writes take one strobe cycle; reads hold rd_en until data returns or a
// cycle budget expires, then the result is parked until the client takes it.
// Optional macro SECMEM_WRITE_PROTECT_EN: writes to key slots (2, 10..13)
// are refused with an error instead of reaching the memory.
module secure_mem_requester #(
   parameter int unsigned WIDTH   = 256,
   parameter int unsigned LENGTH  = 16,
   parameter int unsigned TIMEOUT = 8,
   localparam int unsigned AW     = $clog2(LENGTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   secure_mem_requester_if.slave bus,
   output logic                 mem_rd_en,
   output logic                 mem_wr_en,
   output logic [AW-1:0]        mem_addr,
   output logic [WIDTH-1:0]     mem_wrData,
   input  logic [WIDTH-1:0]     mem_rdData,
   input  logic                 mem_rdData_valid
);

   typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

   state_t           state, state_nx;
   logic [7:0]       cnt, cnt_nx;
   logic [AW-1:0]    addr_q, addr_nx;
   logic [WIDTH-1:0] wdata_q, wdata_nx;
   logic [WIDTH-1:0] rdata_q, rdata_nx;
   logic             err_q, err_nx;
   logic             key_slot_c;

   // Key-slot decode of the incoming address.
`ifdef SECMEM_WRITE_PROTECT_EN
   assign key_slot_c = (32'(bus.req_addr) == 32'd2) ||
                       ((32'(bus.req_addr) >= 32'd10) && (32'(bus.req_addr) <= 32'd13));
`else
   assign key_slot_c = 1'b0;
`endif

   // State and datapath registers; reset abandons any transaction in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         addr_q  <= addr_nx;
         wdata_q <= wdata_nx;
         rdata_q <= rdata_nx;
         err_q   <= err_nx;
      end
   end

   // Next-state and next-datapath logic.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      addr_nx  = addr_q;
      wdata_nx = wdata_q;
      rdata_nx = rdata_q;
      err_nx   = err_q;
      unique case (state)
         IDLE: begin
            if (bus.req_valid) begin
               addr_nx  = bus.req_addr;
               wdata_nx = bus.req_wdata;
               rdata_nx = '0;
               err_nx   = 1'b0;
               cnt_nx   = '0;
               if (!bus.req_write) begin
                  state_nx = READ;
               end else if (key_slot_c) begin
                  err_nx   = 1'b1;
                  state_nx = RESP;
               end else begin
                  state_nx = WRITE;
               end
            end
         end
         WRITE: begin
            state_nx = RESP;
         end
         READ: begin
            cnt_nx = cnt + 8'd1;
            // Valid in the first READ cycle cannot belong to this request.
            if ((cnt != 8'd0) && mem_rdData_valid) begin
               rdata_nx = mem_rdData;
               state_nx = RESP;
            end else if (cnt == 8'(TIMEOUT - 1)) begin
               err_nx   = 1'b1;
               state_nx = RESP;
            end
         end
         RESP: begin
            if (bus.rsp_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // State-decoded outputs; memory side is quiet outside READ/WRITE.
   always_comb begin
      bus.req_ready = (state == IDLE);
      bus.rsp_valid = (state == RESP);
      bus.rsp_rdata = rdata_q;
      bus.rsp_err   = err_q;
      mem_rd_en     = (state == READ);
      mem_wr_en     = (state == WRITE);
      mem_addr      = ((state == READ) || (state == WRITE)) ? addr_q : '0;
      mem_wrData    = (state == WRITE) ? wdata_q : '0;
   end

endmodule

// File: tb/tb_secure_mem_requester.sv
// Directed, table-driven bench for secure_mem_requester with a small
// memory model whose read-return delay is programmable per vector.
module tb_secure_mem_requester;
   localparam int unsigned W  = 256;
   localparam int unsigned AW = 4;
`ifdef SECMEM_WRITE_PROTECT_EN
   localparam bit PROT = 1'b1;
`else
   localparam bit PROT = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          mem_rd_en, mem_wr_en;
   logic [AW-1:0] mem_addr;
   logic [W-1:0]  mem_wrData;
   logic [W-1:0]  mem_rdData = '0;
   logic          mem_rdData_valid = 1'b0;

   secure_mem_requester_if #(.WIDTH(W), .AW(AW)) bus ();

   secure_mem_requester #(.WIDTH(W), .LENGTH(16), .TIMEOUT(8)) dut (
      .clk              (clk),
      .rst              (rst),
      .bus              (bus),
      .mem_rd_en        (mem_rd_en),
      .mem_wr_en        (mem_wr_en),
      .mem_addr         (mem_addr),
      .mem_wrData       (mem_wrData),
      .mem_rdData       (mem_rdData),
      .mem_rdData_valid (mem_rdData_valid)
   );

   always #5 clk = ~clk;

   // Memory model: one valid pulse once rd_en has been sampled mem_delay times.
   int          mem_delay = 0;
   logic [W-1:0] mem_value = '0;
   int          rd_run = 0;
   always @(posedge clk) begin
      if (mem_rd_en) begin
         rd_run           <= rd_run + 1;
         mem_rdData_valid <= (mem_delay != 0) && (rd_run + 1 == mem_delay);
         mem_rdData       <= mem_value;
      end else begin
         rd_run           <= 0;
         mem_rdData_valid <= 1'b0;
         mem_rdData       <= '0;
      end
   end

   int pass_cnt = 0;
   int total    = 0;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      total++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   typedef struct {
      logic         wr;
      logic [AW-1:0] addr;
      logic [W-1:0] wdata;
      int           delay;
      logic [W-1:0] mval;
      int           lat;
      int           rdn;
      int           wrn;
      logic [W-1:0] rdata;
      logic         err;
   } vec_t;

   vec_t vecs[9];

   task automatic run_txn(input vec_t v, input int idx);
      int lat, wr_n, rd_n;
      logic both, busy_rdy;
      logic [AW-1:0] seen_addr;
      logic [W-1:0]  seen_wd;
      lat = 1; wr_n = 0; rd_n = 0; both = 1'b0; busy_rdy = 1'b0;
      seen_addr = '0; seen_wd = '0;
      mem_delay = v.delay;
      mem_value = v.mval;
      @(negedge clk);
      bus.req_write = v.wr;
      bus.req_addr  = v.addr;
      bus.req_wdata = v.wdata;
      bus.req_valid = 1'b1;
      chk($sformatf("v%0d_req_ready", idx), W'(bus.req_ready), W'(1));
      @(negedge clk);
      bus.req_valid = 1'b0;
      while (!bus.rsp_valid && lat < 40) begin
         if (mem_wr_en) begin wr_n++; seen_addr = mem_addr; seen_wd = mem_wrData; end
         if (mem_rd_en) begin rd_n++; seen_addr = mem_addr; end
         if (mem_wr_en && mem_rd_en) both = 1'b1;
         if (bus.req_ready) busy_rdy = 1'b1;
         @(negedge clk);
         lat++;
      end
      chk($sformatf("v%0d_latency", idx), W'(lat), W'(v.lat));
      chk($sformatf("v%0d_rdata", idx), bus.rsp_rdata, v.rdata);
      chk($sformatf("v%0d_err", idx), W'(bus.rsp_err), W'(v.err));
      chk($sformatf("v%0d_wr_pulses", idx), W'(wr_n), W'(v.wrn));
      chk($sformatf("v%0d_rd_cycles", idx), W'(rd_n), W'(v.rdn));
      chk($sformatf("v%0d_busy_flags", idx), W'({both, busy_rdy}), W'(0));
      if (wr_n + rd_n > 0) chk($sformatf("v%0d_mem_addr", idx), W'(seen_addr), W'(v.addr));
      if (wr_n > 0) chk($sformatf("v%0d_mem_wrData", idx), seen_wd, v.wdata);
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      chk($sformatf("v%0d_back_idle", idx), W'({bus.req_ready, bus.rsp_valid}), W'(2'b10));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic stable, idle_ok, ghost;
      logic [W-1:0] held;

      //          wr    addr   wdata        dly mval          lat            rd wr           rdata         err
      vecs[0] = '{1'b1, 4'd5,  W'('hA5),    0,  W'(0),        2,             0, 1,           W'(0),        1'b0};
      vecs[1] = '{1'b0, 4'd10, W'(0),       1,  W'('h1234),   3,             2, 0,           W'('h1234),   1'b0};
      vecs[2] = '{1'b0, 4'd3,  W'(0),       0,  W'('hFF),     9,             8, 0,           W'(0),        1'b1};
      vecs[3] = '{1'b1, 4'd2,  W'('h77),    0,  W'(0),        PROT ? 1 : 2,  0, PROT ? 0 : 1, W'(0),       PROT};
      vecs[4] = '{1'b1, 4'd12, W'('h3C),    0,  W'(0),        PROT ? 1 : 2,  0, PROT ? 0 : 1, W'(0),       PROT};
      vecs[5] = '{1'b1, 4'd15, W'('hDEAD),  0,  W'(0),        2,             0, 1,           W'(0),        1'b0};
      vecs[6] = '{1'b0, 4'd2,  W'(0),       1,  W'('hCAFE),   3,             2, 0,           W'('hCAFE),   1'b0};
      vecs[7] = '{1'b0, 4'd0,  W'(0),       7,  W'('h55),     9,             8, 0,           W'('h55),     1'b0};
      vecs[8] = '{1'b0, 4'd9,  W'(0),       8,  W'('h66),     9,             8, 0,           W'(0),        1'b1};

      bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0;
      bus.req_wdata = '0;   bus.rsp_ready = 1'b0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", W'({bus.req_ready, bus.rsp_valid, bus.rsp_err, mem_rd_en, mem_wr_en}),
          W'(5'b10000));
      chk("reset_rdata", bus.rsp_rdata, W'(0));
      rst = 1'b0;

      for (int i = 0; i < 9; i++) run_txn(vecs[i], i);

      // Response held off by the client: everything must stay frozen.
      mem_delay = 1; mem_value = W'('h9999);
      @(negedge clk);
      bus.req_write = 1'b0; bus.req_addr = 4'd7; bus.req_valid = 1'b1;
      @(negedge clk);
      bus.req_valid = 1'b0;
      n = 0;
      while (!bus.rsp_valid && n < 20) begin @(negedge clk); n++; end
      chk("bp_rsp_arrives", W'(bus.rsp_valid), W'(1));
      held = bus.rsp_rdata;
      stable = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (!bus.rsp_valid || bus.req_ready || bus.rsp_rdata !== held) stable = 1'b0;
      end
      chk("bp_stable", W'(stable), W'(1));
      chk("bp_rdata", held, W'('h9999));
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      chk("bp_release_idle", W'({bus.req_ready, bus.rsp_valid}), W'(2'b10));

      // Reset in the middle of a read: no response may ever surface.
      mem_delay = 0;
      @(negedge clk);
      bus.req_write = 1'b0; bus.req_addr = 4'd4; bus.req_valid = 1'b1;
      @(negedge clk);
      bus.req_valid = 1'b0;
      chk("rst_read_active", W'(mem_rd_en), W'(1));
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_abort", W'({mem_rd_en, bus.rsp_valid, bus.req_ready}), W'(3'b001));
      ghost = 1'b0;
      idle_ok = 1'b1;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (bus.rsp_valid) ghost = 1'b1;
         if (!bus.req_ready || mem_rd_en) idle_ok = 1'b0;
      end
      chk("rst_no_ghost_rsp", W'({ghost, idle_ok}), W'(2'b01));

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule
